// File: rtl/anycore_l15_pkg.sv
// anycore_l15_pkg: shared widths, iop.h type codes and encoder FSM states
package anycore_l15_pkg;
  localparam int PHY_ADDR_WIDTH = 40;
  localparam int ICACHE_OFFSET = 5;
  localparam int DCACHE_OFFSET = 6;
  localparam int ICACHE_BLOCK_ADDR_BITS = PHY_ADDR_WIDTH - ICACHE_OFFSET;
  localparam int DCACHE_BLOCK_ADDR_BITS = PHY_ADDR_WIDTH - DCACHE_OFFSET;
  localparam int BSWAP_BYTES = 8;
  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] EVICT_REQ = 4'b0011;
  localparam logic [3:0] ST_ACK = 4'b0100;
  localparam logic [4:0] LOAD_RQ = 5'b00000;
  localparam logic [4:0] IMISS_RQ = 5'b10000;
  typedef enum logic [1:0] {IDLE, RESP, DRAIN} enc_state_t;
endpackage

// File: rtl/anycore_byteswap64.sv
// anycore_byteswap64: reverse the byte order of a 64-bit word
module anycore_byteswap64
  import anycore_l15_pkg::*;
(
  input  logic [63:0] d,
  output logic [63:0] q
);
  for (genvar i = 0; i < BSWAP_BYTES; i++) begin : g_b
    assign q[8*i +: 8] = d[8*(BSWAP_BYTES-1-i) +: 8];
  end
endmodule

// File: rtl/anycore_encoder.sv
// anycore_encoder: L1.5 returns to AnyCore cache responses; ANYCORE_ENCODER_INV_FWD_EN forwards EVICT_REQ invalidations
module anycore_encoder
  import anycore_l15_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              l15_transducer_val,
  input  logic [3:0]                        l15_transducer_returntype,
  input  logic [63:0]                       l15_transducer_data_0,
  input  logic [63:0]                       l15_transducer_data_1,
  input  logic [63:0]                       l15_transducer_data_2,
  input  logic [63:0]                       l15_transducer_data_3,
  input  logic [11:0]                       l15_transducer_inval_address_15_4,
  output logic                              transducer_l15_req_ack,
  input  logic                              anycoredecoder_l15_val,
  input  logic [4:0]                        anycoredecoder_l15_rqtype,
  input  logic [PHY_ADDR_WIDTH-1:0]         anycoredecoder_l15_address,
  input  logic                              l15_transducer_ack,
  output logic                              anycore_mem2ic_respvalid,
  output logic [ICACHE_BLOCK_ADDR_BITS-1:0] anycore_mem2ic_respaddr,
  output logic [255:0]                      anycore_mem2ic_data,
  output logic                              anycore_mem2dc_ldvalid,
  output logic [DCACHE_BLOCK_ADDR_BITS-1:0] anycore_mem2dc_ldaddr,
  output logic [127:0]                      anycore_mem2dc_lddata,
  output logic                              anycore_mem2dc_stcomplete,
  output logic                              anycore_mem2dc_invvalid,
  output logic [11:0]                       anycore_mem2dc_invaddr,
  output logic                              encoder_err
);
  enc_state_t state, state_nx;
  logic [3:0] rt_q;
  logic [63:0] d_q [4];
  logic [63:0] bs_in [6];
  logic [63:0] bs_out [6];
  logic ic_pend, dc_pend;
  logic [ICACHE_BLOCK_ADDR_BITS-1:0] ic_addr;
  logic [DCACHE_BLOCK_ADDR_BITS-1:0] dc_addr;
  logic resp, take, is_ld, is_ic, is_st, is_ev, bad_rt;
  logic ic_cap, dc_cap, ic_clr, dc_clr;
  logic unused;
  assign resp = state == RESP;
  assign take = state == IDLE && l15_transducer_val;
  assign is_ld = rt_q == LOAD_RET;
  assign is_ic = rt_q == IFILL_RET;
  assign is_st = rt_q == ST_ACK;
  assign is_ev = rt_q == EVICT_REQ;
  assign bad_rt = !(is_ld || is_ic || is_st || is_ev);
  assign ic_cap = l15_transducer_ack && anycoredecoder_l15_val && anycoredecoder_l15_rqtype == IMISS_RQ;
  assign dc_cap = l15_transducer_ack && anycoredecoder_l15_val && anycoredecoder_l15_rqtype == LOAD_RQ;
  assign ic_clr = resp && is_ic;
  assign dc_clr = resp && is_ld;
  assign bs_in = '{d_q[0], d_q[1], d_q[2], d_q[3], d_q[0], d_q[1]};
  for (genvar g = 0; g < 6; g++) begin : g_bs
    anycore_byteswap64 u_bs (.d(bs_in[g]), .q(bs_out[g]));
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // IDLE waits for a packet, RESP emits it, DRAIN masks the still-held val for one cycle
  always_comb begin
    state_nx = IDLE;
    state_nx = take ? RESP : resp ? DRAIN : IDLE;
  end
  // latch the return packet when it is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rt_q <= '0;
      d_q <= '{default: '0};
    end else if (take) begin
      rt_q <= l15_transducer_returntype;
      d_q <= '{l15_transducer_data_0, l15_transducer_data_1, l15_transducer_data_2, l15_transducer_data_3};
    end
  // outstanding miss addresses; a new capture wins over a same-cycle delivery clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ic_pend <= 1'b0;
      dc_pend <= 1'b0;
      ic_addr <= '0;
      dc_addr <= '0;
    end else begin
      ic_pend <= ic_cap || (ic_pend && !ic_clr);
      dc_pend <= dc_cap || (dc_pend && !dc_clr);
      if (ic_cap) ic_addr <= anycoredecoder_l15_address[PHY_ADDR_WIDTH-1:ICACHE_OFFSET];
      if (dc_cap) dc_addr <= anycoredecoder_l15_address[PHY_ADDR_WIDTH-1:DCACHE_OFFSET];
    end
  // one-cycle registered response and ack, zero outside the pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      transducer_l15_req_ack <= 1'b0;
      anycore_mem2ic_respvalid <= 1'b0;
      anycore_mem2ic_respaddr <= '0;
      anycore_mem2ic_data <= '0;
      anycore_mem2dc_ldvalid <= 1'b0;
      anycore_mem2dc_ldaddr <= '0;
      anycore_mem2dc_lddata <= '0;
      anycore_mem2dc_stcomplete <= 1'b0;
    end else begin
      transducer_l15_req_ack <= resp;
      anycore_mem2ic_respvalid <= ic_clr;
      anycore_mem2ic_respaddr <= ic_clr && ic_pend ? ic_addr : '0;
      anycore_mem2ic_data <= ic_clr ? {bs_out[3], bs_out[2], bs_out[1], bs_out[0]} : '0;
      anycore_mem2dc_ldvalid <= dc_clr;
      anycore_mem2dc_ldaddr <= dc_clr && dc_pend ? dc_addr : '0;
      anycore_mem2dc_lddata <= dc_clr ? {bs_out[5], bs_out[4]} : '0;
      anycore_mem2dc_stcomplete <= resp && is_st;
    end
  // sticky error: overwritten miss, orphan return, or unknown return type
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) encoder_err <= 1'b0;
    else if ((ic_cap && ic_pend && !ic_clr) || (dc_cap && dc_pend && !dc_clr) ||
             (ic_clr && !ic_pend) || (dc_clr && !dc_pend) || (resp && bad_rt))
      encoder_err <= 1'b1;
`ifdef ANYCORE_ENCODER_INV_FWD_EN
  logic [11:0] inv_q;
  // latch and forward the eviction line index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inv_q <= '0;
      anycore_mem2dc_invvalid <= 1'b0;
      anycore_mem2dc_invaddr <= '0;
    end else begin
      if (take) inv_q <= l15_transducer_inval_address_15_4;
      anycore_mem2dc_invvalid <= resp && is_ev;
      anycore_mem2dc_invaddr <= resp && is_ev ? inv_q : '0;
    end
  assign unused = ^anycoredecoder_l15_address[ICACHE_OFFSET-1:0];
`else
  assign anycore_mem2dc_invvalid = 1'b0;
  assign anycore_mem2dc_invaddr = '0;
  assign unused = ^{anycoredecoder_l15_address[ICACHE_OFFSET-1:0], l15_transducer_inval_address_15_4};
`endif
endmodule

// File: tb/tb_anycore_encoder.sv
// tb_anycore_encoder: table-driven directed check of anycore_encoder
module tb_anycore_encoder;
  import anycore_l15_pkg::*;
`ifdef ANYCORE_ENCODER_INV_FWD_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif
  typedef struct {
    logic req;
    logic [4:0] rq;
    logic [39:0] addr;
    logic [3:0] rt;
    logic [63:0] d0, d1, d2, d3;
    logic [11:0] inva;
    logic e_ld, e_ic, e_st, e_inv;
    logic [255:0] e_data;
    logic [39:0] e_addr;
    logic e_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic val = 1'b0;
  logic [3:0] rt = '0;
  logic [63:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [11:0] inva = '0;
  logic ack;
  logic dec_val = 1'b0;
  logic [4:0] rq = '0;
  logic [39:0] addr = '0;
  logic l15_ack = 1'b0;
  logic ic_valid, ld_valid, st, inv, err;
  logic [34:0] ic_addr;
  logic [33:0] ld_addr;
  logic [255:0] ic_data;
  logic [127:0] ld_data;
  logic [11:0] inv_addr;
  int total = 0;
  int bad = 0;
  vec_t tbl [7];
  always #5 clk = ~clk;
  anycore_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .l15_transducer_val(val), .l15_transducer_returntype(rt),
    .l15_transducer_data_0(d0), .l15_transducer_data_1(d1),
    .l15_transducer_data_2(d2), .l15_transducer_data_3(d3),
    .l15_transducer_inval_address_15_4(inva),
    .transducer_l15_req_ack(ack),
    .anycoredecoder_l15_val(dec_val), .anycoredecoder_l15_rqtype(rq),
    .anycoredecoder_l15_address(addr), .l15_transducer_ack(l15_ack),
    .anycore_mem2ic_respvalid(ic_valid), .anycore_mem2ic_respaddr(ic_addr),
    .anycore_mem2ic_data(ic_data),
    .anycore_mem2dc_ldvalid(ld_valid), .anycore_mem2dc_ldaddr(ld_addr),
    .anycore_mem2dc_lddata(ld_data),
    .anycore_mem2dc_stcomplete(st),
    .anycore_mem2dc_invvalid(inv), .anycore_mem2dc_invaddr(inv_addr),
    .encoder_err(err)
  );
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic quiet(input string name);
    chk(name, {ack, ic_valid, ld_valid, st, inv, |ic_addr, |ic_data, |ld_addr, |ld_data, |inv_addr}, '0);
  endtask
  task automatic issue(input logic [4:0] r, input logic [39:0] a);
    dec_val = 1'b1;
    l15_ack = 1'b1;
    rq = r;
    addr = a;
    @(negedge clk);
    dec_val = 1'b0;
    l15_ack = 1'b0;
  endtask
  task automatic txn(input vec_t v);
    int n;
    val = 1'b1;
    rt = v.rt;
    {d0, d1, d2, d3} = {v.d0, v.d1, v.d2, v.d3};
    inva = v.inva;
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (ack) break;
    end
    val = 1'b0;
    chk("latency", n, 2);
    chk("ldvalid", ld_valid, v.e_ld);
    chk("lddata", ld_data, v.e_ld ? v.e_data[127:0] : '0);
    chk("ldaddr", ld_addr, v.e_ld ? v.e_addr : '0);
    chk("icvalid", ic_valid, v.e_ic);
    chk("icdata", ic_data, v.e_ic ? v.e_data : '0);
    chk("icaddr", ic_addr, v.e_ic ? v.e_addr : '0);
    chk("stcomplete", st, v.e_st);
    chk("invvalid", inv, v.e_inv);
    chk("invaddr", inv_addr, v.e_inv ? v.inva : '0);
    chk("err", err, v.e_err);
    @(negedge clk);
    quiet("after_pulse");
  endtask
  initial begin
    vec_t v;
    int cnt, p0, p1;
    tbl[0] = '{1'b1, LOAD_RQ, 40'h80_0000_1040, LOAD_RET, 64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0, 64'h0, 12'h0,
               1'b1, 1'b0, 1'b0, 1'b0, {128'h0, 64'hFFEEDDCCBBAA9988, 64'h7766554433221100}, 40'h2_0000_0041, 1'b0};
    tbl[1] = '{1'b1, IMISS_RQ, 40'h4000, IFILL_RET, 64'h0102030405060708, 64'h1112131415161718, 64'h2122232425262728,
               64'h3132333435363738, 12'h0, 1'b0, 1'b1, 1'b0, 1'b0,
               {64'h3837363534333231, 64'h2827262524232221, 64'h1817161514131211, 64'h0807060504030201}, 40'h200, 1'b0};
    tbl[2] = '{1'b0, LOAD_RQ, 40'h0, ST_ACK, 64'h0, 64'h0, 64'h0, 64'h0, 12'h0, 1'b0, 1'b0, 1'b1, 1'b0, 256'h0, 40'h0, 1'b0};
    tbl[3] = '{1'b0, LOAD_RQ, 40'h0, EVICT_REQ, 64'h0, 64'h0, 64'h0, 64'h0, 12'hABC, 1'b0, 1'b0, 1'b0, INV_EN, 256'h0, 40'h0, 1'b0};
    tbl[4] = '{1'b0, LOAD_RQ, 40'h0, IFILL_RET, 64'hDEADBEEF00000000, 64'h0, 64'h0, 64'h0, 12'h0, 1'b0, 1'b1, 1'b0, 1'b0,
               {192'h0, 64'h00000000EFBEADDE}, 40'h0, 1'b1};
    tbl[5] = '{1'b0, LOAD_RQ, 40'h0, LOAD_RET, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0,
               {192'h0, 64'h0807060504030201}, 40'h0, 1'b1};
    tbl[6] = '{1'b0, LOAD_RQ, 40'h0, 4'hF, 64'h0, 64'h0, 64'h0, 64'h0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 256'h0, 40'h0, 1'b1};
    repeat (2) @(negedge clk);
    quiet("reset_outputs");
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].req) issue(tbl[i].rq, tbl[i].addr);
      txn(tbl[i]);
    end
    chk("err_sticky", err, 1);
    val = 1'b1;
    rt = ST_ACK;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 quiet("reset_mid_resp");
    chk("reset_mid_err", err, 0);
    @(negedge clk);
    val = 1'b0;
    chk("reset_mid_noack", ack, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      quiet("post_reset_idle");
    end
    issue(LOAD_RQ, 40'h1000);
    val = 1'b1;
    rt = LOAD_RET;
    @(negedge clk);
    issue(LOAD_RQ, 40'h2000);
    val = 1'b0;
    chk("same_cycle_ack", ack, 1);
    chk("same_cycle_ldaddr", ld_addr, 34'h40);
    chk("same_cycle_err", err, 0);
    @(negedge clk);
    v = '{1'b0, LOAD_RQ, 40'h0, LOAD_RET, 64'h0, 64'h0, 64'h0, 64'h0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0, 256'h0, 40'h80, 1'b0};
    txn(v);
    issue(LOAD_RQ, 40'h3000);
    issue(LOAD_RQ, 40'h5000);
    chk("overwrite_err", err, 1);
    v = '{1'b0, LOAD_RQ, 40'h0, LOAD_RET, 64'h0, 64'h0, 64'h0, 64'h0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0, 256'h0, 40'h140, 1'b1};
    txn(v);
    val = 1'b1;
    rt = ST_ACK;
    cnt = 0;
    p0 = 0;
    p1 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (st) begin
        cnt++;
        if (cnt == 1) p0 = k;
        else p1 = k;
      end
      if (ack && cnt == 2) val = 1'b0;
    end
    chk("held_st_count", cnt, 2);
    chk("held_st_gap", p1 - p0, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
